// File: rtl/div_iter_pkg.sv
// Shared types and defaults for the iterative integer divider.
package div_iter_pkg;

    localparam int unsigned XLEN_DEF = 32;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_ITER = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } div_state_e;

endpackage

// File: rtl/div_clz.sv
// Combinational leading-zero count; returns XLEN for an all-zero input.
module div_clz #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned CW   = $clog2(XLEN) + 1
) (
    input  logic [XLEN-1:0] value_i,
    output logic [CW-1:0]   count_o
);

    // Highest set bit wins because it is visited last.
    always_comb begin
        count_o = CW'(XLEN);
        for (int i = 0; i < XLEN; i++) begin
            if (value_i[i]) begin
                count_o = CW'(XLEN - 1 - i);
            end
        end
    end

endmodule

// File: rtl/div_iter.sv
// Iterative restoring divider (DIV/DIVU/REM/REMU) with start/valid handshake and flush.
module div_iter
    import div_iter_pkg::*;
#(
    parameter int unsigned XLEN      = XLEN_DEF,
    parameter bit          EARLY_OUT = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            div_sign,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            flush,
    output logic            busy,
    output logic            out_valid,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            div_zero
);

    localparam int unsigned CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e      state_q, state_d;
    logic [XLEN-1:0] dq_q, dq_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            dvd_neg_q, dvd_neg_d;
    logic            dvs_neg_q, dvs_neg_d;
    logic            special_q, special_d;
    logic            dz_q, dz_d;
    logic [XLEN-1:0] quotient_q, quotient_d;
    logic [XLEN-1:0] remainder_q, remainder_d;
    logic            div_zero_q, div_zero_d;
    logic            busy_q, out_valid_q;

    logic [XLEN-1:0] dvd_abs_c;
    logic [CW-1:0]   clz_c;
    logic [XLEN:0]   trial_c;

    // dq_q holds the raw dividend until PREP, then the shifting dividend/quotient.
    assign dvd_abs_c = dvd_neg_q ? -dq_q : dq_q;
    assign trial_c   = {rem_q, dq_q[XLEN-1]} - {1'b0, dvs_q};

    generate
        if (EARLY_OUT) begin : g_clz
            div_clz #(.XLEN(XLEN), .CW(CW)) u_clz (
                .value_i (dvd_abs_c),
                .count_o (clz_c)
            );
        end else begin : g_no_clz
            assign clz_c = '0;
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        dq_d        = dq_q;
        rem_d       = rem_q;
        dvs_d       = dvs_q;
        cnt_d       = cnt_q;
        dvd_neg_d   = dvd_neg_q;
        dvs_neg_d   = dvs_neg_q;
        special_d   = special_q;
        dz_d        = dz_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;

        case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    state_d   = ST_PREP;
                    dq_d      = dividend;
                    dvd_neg_d = div_sign & dividend[XLEN-1];
                    dvs_neg_d = div_sign & divisor[XLEN-1];
                    dvs_d     = dvs_neg_d ? -divisor : divisor;
                    rem_d     = '0;
                    cnt_d     = '0;
                    special_d = 1'b0;
                    dz_d      = 1'b0;
                end
            end
            ST_PREP: begin
                state_d = ST_FIX;
                if (dvs_q == '0) begin
                    special_d = 1'b1;
                    dz_d      = 1'b1;
                    rem_d     = dq_q;
                    dq_d      = '1;
                end else if (dvd_neg_q && dvs_neg_q && dq_q == MOST_NEG
                             && dvs_q == XLEN'(1)) begin
                    special_d = 1'b1;
                    rem_d     = '0;
                end else if (EARLY_OUT && dq_q == '0) begin
                    special_d = 1'b1;
                    dq_d      = '0;
                    rem_d     = '0;
                end else begin
                    // Align the top significant dividend bit to the MSB.
                    state_d = ST_ITER;
                    dq_d    = dvd_abs_c << clz_c;
                    rem_d   = '0;
                    cnt_d   = CW'(XLEN) - clz_c;
                end
            end
            ST_ITER: begin
                if (!trial_c[XLEN]) begin
                    rem_d = trial_c[XLEN-1:0];
                end else begin
                    rem_d = {rem_q[XLEN-2:0], dq_q[XLEN-1]};
                end
                dq_d  = {dq_q[XLEN-2:0], ~trial_c[XLEN]};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                state_d    = ST_DONE;
                div_zero_d = dz_q;
                if (special_q) begin
                    quotient_d  = dq_q;
                    remainder_d = rem_q;
                end else begin
                    quotient_d  = (dvd_neg_q ^ dvs_neg_q) ? -dq_q : dq_q;
                    remainder_d = dvd_neg_q ? -rem_q : rem_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A kill returns to IDLE and leaves the visible results untouched.
        if (flush && state_q != ST_IDLE) begin
            state_d     = ST_IDLE;
            quotient_d  = quotient_q;
            remainder_d = remainder_q;
            div_zero_d  = div_zero_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            dq_q        <= '0;
            rem_q       <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            dvd_neg_q   <= 1'b0;
            dvs_neg_q   <= 1'b0;
            special_q   <= 1'b0;
            dz_q        <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dq_q        <= dq_d;
            rem_q       <= rem_d;
            dvs_q       <= dvs_d;
            cnt_q       <= cnt_d;
            dvd_neg_q   <= dvd_neg_d;
            dvs_neg_q   <= dvs_neg_d;
            special_q   <= special_d;
            dz_q        <= dz_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
            busy_q      <= (state_d != ST_IDLE);
            out_valid_q <= (state_d == ST_DONE);
        end
    end

    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_div_iter.sv
// Bench for div_iter: six instances (XLEN 8/32/64 x EARLY_OUT 0/1) on shared stimulus.
module tb_div_iter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        div_sign = 1'b0;
    logic        flush = 1'b0;
    logic [63:0] a_drv = '0;
    logic [63:0] b_drv = '0;

    logic [7:0]  q8[2],  r8[2];
    logic [31:0] q32[2], r32[2];
    logic [63:0] q64[2], r64[2];
    logic [5:0]  busy_w, vld_w, dz_w;

    int tests = 0;
    int fails = 0;

    int          lat_r[6];
    int          cnt_r[6];
    logic [63:0] gq[6], gr[6];
    logic        gdz[6];

    always #5 clk = ~clk;

    // Instance index d: 0/1 = XLEN 8, 2/3 = XLEN 32, 4/5 = XLEN 64; odd d has EARLY_OUT=1.
    generate
        for (genvar e = 0; e < 2; e++) begin : g_w8
            div_iter #(.XLEN(8), .EARLY_OUT(e == 1)) u_dut (
                .clk(clk), .rst_n(rst_n), .start(start), .div_sign(div_sign),
                .dividend(a_drv[7:0]), .divisor(b_drv[7:0]), .flush(flush),
                .busy(busy_w[e]), .out_valid(vld_w[e]), .quotient(q8[e]),
                .remainder(r8[e]), .div_zero(dz_w[e]));
        end
        for (genvar e = 0; e < 2; e++) begin : g_w32
            div_iter #(.XLEN(32), .EARLY_OUT(e == 1)) u_dut (
                .clk(clk), .rst_n(rst_n), .start(start), .div_sign(div_sign),
                .dividend(a_drv[31:0]), .divisor(b_drv[31:0]), .flush(flush),
                .busy(busy_w[e+2]), .out_valid(vld_w[e+2]), .quotient(q32[e]),
                .remainder(r32[e]), .div_zero(dz_w[e+2]));
        end
        for (genvar e = 0; e < 2; e++) begin : g_w64
            div_iter #(.XLEN(64), .EARLY_OUT(e == 1)) u_dut (
                .clk(clk), .rst_n(rst_n), .start(start), .div_sign(div_sign),
                .dividend(a_drv), .divisor(b_drv), .flush(flush),
                .busy(busy_w[e+4]), .out_valid(vld_w[e+4]), .quotient(q64[e]),
                .remainder(r64[e]), .div_zero(dz_w[e+4]));
        end
    endgenerate

    function automatic int wid(input int d);
        return (d < 2) ? 8 : ((d < 4) ? 32 : 64);
    endfunction

    function automatic logic [63:0] obs_q(input int d);
        case (d)
            0: return 64'(q8[0]);
            1: return 64'(q8[1]);
            2: return 64'(q32[0]);
            3: return 64'(q32[1]);
            4: return q64[0];
            default: return q64[1];
        endcase
    endfunction

    function automatic logic [63:0] obs_r(input int d);
        case (d)
            0: return 64'(r8[0]);
            1: return 64'(r8[1]);
            2: return 64'(r32[0]);
            3: return 64'(r32[1]);
            4: return r64[0];
            default: return r64[1];
        endcase
    endfunction

    // Reference: plain integer division with the RISC-V special-case rules.
    function automatic void model(input int w, input bit eo, input logic [63:0] a_in,
                                  input logic [63:0] b_in, input bit sgn,
                                  output logic [63:0] q, output logic [63:0] r,
                                  output logic dz, output int lat);
        logic [63:0] mask, a, b, mag, mn;
        longint      sa, sb;
        int          n;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        a    = a_in & mask;
        b    = b_in & mask;
        mn   = 64'd1 << (w - 1);
        q = '0; r = '0; dz = 1'b0; lat = 3;
        if (b == '0) begin
            q = mask; r = a; dz = 1'b1;
            return;
        end
        if (sgn && a == mn && b == mask) begin
            q = a;
            return;
        end
        if (eo && a == '0) return;
        mag = (sgn && a[w-1]) ? ((~a + 64'd1) & mask) : a;
        if (sgn) begin
            sa = a[w-1] ? longint'(a | ~mask) : longint'(a);
            sb = b[w-1] ? longint'(b | ~mask) : longint'(b);
            q  = 64'(sa / sb) & mask;
            r  = 64'(sa % sb) & mask;
        end else begin
            q = a / b;
            r = a % b;
        end
        n = w;
        if (eo) begin
            n = 0;
            for (int i = 0; i < w; i++) if (mag[i]) n = i + 1;
        end
        lat = n + 3;
    endfunction

    // Issue one operation (caller is at a negedge) and record each instance's result.
    task automatic issue(input logic [63:0] a, input logic [63:0] b, input bit sgn,
                         input bit stray);
        for (int d = 0; d < 6; d++) begin
            lat_r[d] = -1; cnt_r[d] = 0; gq[d] = '0; gr[d] = '0; gdz[d] = 1'b0;
        end
        a_drv = a; b_drv = b; div_sign = sgn; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 150; k++) begin
            for (int d = 0; d < 6; d++) begin
                if (vld_w[d]) begin
                    cnt_r[d]++; lat_r[d] = k;
                    gq[d] = obs_q(d); gr[d] = obs_r(d); gdz[d] = dz_w[d];
                end
            end
            if (busy_w == '0) break;
            if (stray && busy_w == '1 && $urandom_range(0, 3) == 0) begin
                start    = 1'b1;
                a_drv    = {$urandom, $urandom};
                b_drv    = {$urandom, $urandom};
                div_sign = 1'($urandom_range(0, 1));
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        tests++;
        if (busy_w !== '0 || vld_w !== '0 || dz_w !== '0) begin
            fails++;
            $display("FAIL reset_flags busy=%b vld=%b dz=%b expected all 0", busy_w, vld_w, dz_w);
        end
        for (int d = 0; d < 6; d++) begin
            tests++;
            if (obs_q(d) !== '0 || obs_r(d) !== '0) begin
                fails++;
                $display("FAIL reset_results d=%0d q=%h r=%h expected 0", d, obs_q(d), obs_r(d));
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_unsigned();
        issue(64'd100, 64'd7, 1'b0, 1'b0);
        tests++;
        if (gq[2] !== 64'd14 || gr[2] !== 64'd2 || gdz[2] !== 1'b0) begin
            fails++;
            $display("FAIL udiv_100_7 q=%0d r=%0d dz=%b expected 14 2 0", gq[2], gr[2], gdz[2]);
        end
        tests++;
        if (lat_r[2] !== 35 || cnt_r[2] !== 1) begin
            fails++;
            $display("FAIL udiv_latency lat=%0d pulses=%0d expected 35 1", lat_r[2], cnt_r[2]);
        end
    endtask

    task automatic test_signed();
        issue(64'hFFFF_FFF9, 64'd2, 1'b1, 1'b0);
        tests++;
        if (gq[2] !== 64'hFFFF_FFFD || gr[2] !== 64'hFFFF_FFFF) begin
            fails++;
            $display("FAIL sdiv_m7_2 q=%h r=%h expected fffffffd ffffffff", gq[2], gr[2]);
        end
        issue(64'd7, 64'hFFFF_FFFE, 1'b1, 1'b0);
        tests++;
        if (gq[3] !== 64'hFFFF_FFFD || gr[3] !== 64'd1) begin
            fails++;
            $display("FAIL sdiv_7_m2 q=%h r=%h expected fffffffd 1", gq[3], gr[3]);
        end
    endtask

    task automatic test_special();
        issue(64'h1234, 64'd0, 1'b0, 1'b0);
        tests++;
        if (gq[2] !== 64'hFFFF_FFFF || gr[2] !== 64'h1234 || gdz[2] !== 1'b1 || lat_r[2] !== 3) begin
            fails++;
            $display("FAIL div_zero q=%h r=%h dz=%b lat=%0d expected ffffffff 1234 1 3",
                     gq[2], gr[2], gdz[2], lat_r[2]);
        end
        issue(64'h8000_0000, 64'hFFFF_FFFF, 1'b1, 1'b0);
        tests++;
        if (gq[2] !== 64'h8000_0000 || gr[2] !== 64'd0 || gdz[2] !== 1'b0 || lat_r[2] !== 3) begin
            fails++;
            $display("FAIL overflow q=%h r=%h dz=%b lat=%0d expected 80000000 0 0 3",
                     gq[2], gr[2], gdz[2], lat_r[2]);
        end
    endtask

    task automatic test_early_out();
        issue(64'd5, 64'd3, 1'b0, 1'b0);
        tests++;
        if (gq[3] !== 64'd1 || gr[3] !== 64'd2 || lat_r[3] !== 6) begin
            fails++;
            $display("FAIL early_out_5_3 q=%0d r=%0d lat=%0d expected 1 2 6", gq[3], gr[3], lat_r[3]);
        end
        tests++;
        if (lat_r[1] !== 6 || gq[1] !== 64'd1) begin
            fails++;
            $display("FAIL early_out_w8 q=%0d lat=%0d expected 1 6", gq[1], lat_r[1]);
        end
    endtask

    task automatic test_flush();
        bit seen = 1'b0;
        a_drv = 64'hF0F0_F0F7; b_drv = 64'd3; div_sign = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k < 10; k++) begin
            if (vld_w != '0) seen = 1'b1;
            @(negedge clk);
        end
        if (vld_w != '0) seen = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        tests++;
        if (busy_w !== '0 || vld_w !== '0 || seen) begin
            fails++;
            $display("FAIL flush_abort busy=%b vld=%b early_valid=%b expected 0 0 0", busy_w, vld_w, seen);
        end
        tests++;
        if (q32[0] !== 32'd1 || r32[0] !== 32'd2) begin
            fails++;
            $display("FAIL flush_hold q=%0d r=%0d expected 1 2", q32[0], r32[0]);
        end
        issue(64'd1000, 64'd10, 1'b0, 1'b0);
        tests++;
        if (gq[2] !== 64'd100 || gr[2] !== 64'd0 || lat_r[2] !== 35 || cnt_r[2] !== 1) begin
            fails++;
            $display("FAIL after_flush q=%0d r=%0d lat=%0d pulses=%0d expected 100 0 35 1",
                     gq[2], gr[2], lat_r[2], cnt_r[2]);
        end
        start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        seen = (busy_w != '0);
        repeat (3) begin
            @(negedge clk);
            if (busy_w != '0 || vld_w != '0) seen = 1'b1;
        end
        tests++;
        if (seen) begin
            fails++;
            $display("FAIL flush_start_drop busy=%b vld=%b expected request dropped", busy_w, vld_w);
        end
    endtask

    task automatic test_reset_mid_iter();
        a_drv = '1; b_drv = 64'd3; div_sign = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        tests++;
        if (busy_w !== '1) begin
            fails++;
            $display("FAIL pre_reset_busy busy=%b expected 111111", busy_w);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (busy_w !== '0 || vld_w !== '0 || dz_w !== '0) begin
            fails++;
            $display("FAIL async_reset_flags busy=%b vld=%b dz=%b expected 0", busy_w, vld_w, dz_w);
        end
        for (int d = 0; d < 6; d++) begin
            tests++;
            if (obs_q(d) !== '0 || obs_r(d) !== '0) begin
                fails++;
                $display("FAIL async_reset_results d=%0d q=%h r=%h expected 0", d, obs_q(d), obs_r(d));
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [63:0] a, b, eq, er;
        logic        edz;
        int          elat, sel;
        bit          sgn;
        for (int it = 0; it < 40; it++) begin
            a   = {$urandom, $urandom};
            a   = a >> $urandom_range(0, 63);
            b   = {$urandom, $urandom};
            b   = b >> $urandom_range(0, 63);
            sgn = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 9);
            case (sel)
                0: b = '0;
                1: begin a = 64'h8000_0000; b = '1; sgn = 1'b1; end
                2: begin a = 64'h80; b = '1; sgn = 1'b1; end
                3: begin a = 64'h8000_0000_0000_0000; b = '1; sgn = 1'b1; end
                4: a = {$urandom, $urandom};
                default: ;
            endcase
            issue(a, b, sgn, 1'b1);
            for (int d = 0; d < 6; d++) begin
                model(wid(d), (d % 2) == 1, a, b, sgn, eq, er, edz, elat);
                tests++;
                if (gq[d] !== eq || gr[d] !== er || gdz[d] !== edz) begin
                    fails++;
                    $display("FAIL rand_result d=%0d a=%h b=%h s=%b q=%h r=%h dz=%b expected %h %h %b",
                             d, a, b, sgn, gq[d], gr[d], gdz[d], eq, er, edz);
                end
                tests++;
                if (lat_r[d] !== elat || cnt_r[d] !== 1) begin
                    fails++;
                    $display("FAIL rand_timing d=%0d a=%h lat=%0d pulses=%0d expected %0d 1",
                             d, a, lat_r[d], cnt_r[d], elat);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_special();
        test_early_out();
        test_flush();
        test_reset_mid_iter();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
